// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide execute unit. Shift-add
//               multiply and restoring divide, STEP bits resolved per cycle,
//               with single-cycle handling of divide-by-zero and signed
//               overflow. Valid/ready handshake on both request and result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [RD_W-1:0] rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out,
    output logic            busy
);

    localparam int N     = XLEN / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW    = 2 * XLEN + 1;
    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              sign_a_q, sign_a_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sgn_a_en, sgn_b_en, in_sign_a, in_sign_b, is_fast;
    logic [XLEN-1:0]   in_mag_a, in_mag_b, fast_res;
    logic              step_div;
    logic [XLEN-1:0]   step_b;
    logic [AW-1:0]     step_acc;
    logic [XLEN:0]     step_hi;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;
    logic [CNT_W-1:0]  cnt_inc;

    assign in_ready  = (state_q == S_IDLE) & ~flush;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Decode operand signedness and magnitudes; detect the divide special cases
    always_comb begin
        sgn_a_en = 1'b0;
        sgn_b_en = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a_en = 1'b1;
                sgn_b_en = 1'b1;
            end
            3'b010:  sgn_a_en = 1'b1;
            default: ;
        endcase
        in_sign_a = sgn_a_en & a[XLEN-1];
        in_sign_b = sgn_b_en & b[XLEN-1];
        in_mag_a  = in_sign_a ? (~a + 1'b1) : a;
        in_mag_b  = in_sign_b ? (~b + 1'b1) : b;
        is_fast   = 1'b0;
        fast_res  = '0;
        if (funct3[2]) begin
            if (b == '0) begin
                is_fast  = 1'b1;
                fast_res = funct3[1] ? a : '1;
            end else if (!funct3[0] && (a == C_INT_MIN) && (b == '1)) begin
                is_fast  = 1'b1;
                fast_res = funct3[1] ? '0 : a;
            end
        end
    end

    // One iteration: STEP shift-add multiply or restoring divide steps; the
    // accept edge already performs the first iteration from the raw operands
    always_comb begin
        if (state_q == S_IDLE) begin
            step_div = funct3[2];
            step_b   = in_mag_b;
            step_acc = {{(XLEN+1){1'b0}}, in_mag_a};
        end else begin
            step_div = op_q[2];
            step_b   = opb_q;
            step_acc = acc_q;
        end
        step_hi = '0;
        for (int i = 0; i < STEP; i++) begin
            if (step_div) begin
                step_acc = step_acc << 1;
                if (step_acc[AW-1:XLEN] >= {1'b0, step_b}) begin
                    step_acc[AW-1:XLEN] = step_acc[AW-1:XLEN] - {1'b0, step_b};
                    step_acc[0]         = 1'b1;
                end
            end else begin
                step_hi  = step_acc[AW-1:XLEN] + (step_acc[0] ? {1'b0, step_b} : '0);
                step_acc = {step_hi, step_acc[XLEN-1:0]} >> 1;
            end
        end
    end

    // Sign correction of product/quotient/remainder and final result select
    always_comb begin
        prod_s = neg_q    ? (~acc_q[2*XLEN-1:0] + 1'b1)    : acc_q[2*XLEN-1:0];
        quo_s  = neg_q    ? (~acc_q[XLEN-1:0] + 1'b1)      : acc_q[XLEN-1:0];
        rem_s  = sign_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    // Control FSM: accept, iterate, fix up, hold result until consumed
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d     = funct3;
                        rd_d     = rd_in;
                        sign_a_d = in_sign_a;
                        neg_d    = in_sign_a ^ in_sign_b;
                        opb_d    = in_mag_b;
                        cnt_d    = '0;
                        if (is_fast) begin
                            result_d = fast_res;
                            state_d  = S_DONE;
                        end else begin
                            acc_d   = step_acc;
                            state_d = (N == 1) ? S_FIX : S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(N - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire
